// File: rtl/aclk_key_decoder.sv
// Keypad decoder for the alarm clock: turns ASCII key codes into the key_time
// digit plus the show/load controls for the display mux and time/alarm registers.
//
// Ports
//   clock, reset_n          : clock and asynchronous active-low reset
//   key_valid / key_ready   : key_code handshake (accepted when both high at an edge)
//   key_code [7:0]          : ASCII key ('0'-'9', 'A', 'T', 'C')
//   key_time [3:0]          : last entered digit
//   show_new_time           : entry in progress, display shows key_time
//   load_new_a / load_new_c : one-cycle load strobes (alarm / current time)
//   key_error               : one-cycle strobe, accepted code was not a legal key
module aclk_key_decoder #(
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TIMER_W = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_code,
  output logic [3:0] key_time,
  output logic       show_new_time,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       key_error
);

  localparam int unsigned CODE_W = 8;
  localparam int unsigned DIGIT_W = 4;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  state_e               state_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [DIGIT_W-1:0]   key_time_q;
  logic                 show_q;
  logic                 load_a_q;
  logic                 load_c_q;
  logic                 error_q;
  logic                 ready_q;

  logic                 accept_c;
  logic                 is_digit_c;
  logic                 is_a_c;
  logic                 is_t_c;
  logic                 is_c_c;
  logic [DIGIT_W-1:0]   digit_c;
  logic                 timeout_c;

  // Key decode; for '0'-'9' the low nibble of the ASCII code is the digit value.
  always_comb begin
    accept_c   = key_valid && ready_q;
    is_digit_c = (key_code >= CODE_W'(8'h30)) && (key_code <= CODE_W'(8'h39));
    is_a_c     = (key_code == CODE_W'(8'h41));
    is_t_c     = (key_code == CODE_W'(8'h54));
    is_c_c     = (key_code == CODE_W'(8'h43));
    digit_c    = key_code[DIGIT_W-1:0];
    timeout_c  = (timer_q == TIMER_LAST);
  end

  // Session FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      key_time_q <= '0;
      show_q     <= 1'b0;
      load_a_q   <= 1'b0;
      load_c_q   <= 1'b0;
      error_q    <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      load_a_q <= 1'b0;
      load_c_q <= 1'b0;
      error_q  <= 1'b0;
      ready_q  <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            if (is_digit_c) begin
              key_time_q <= digit_c;
              show_q     <= 1'b1;
              timer_q    <= '0;
              state_q    <= ST_ENTRY;
            end else if (!(is_a_c || is_t_c || is_c_c)) begin
              error_q <= 1'b1;
            end
          end
        end
        ST_ENTRY: begin
          if (accept_c && is_digit_c) begin
            key_time_q <= digit_c;
            timer_q    <= '0;
          end else if (accept_c && (is_a_c || is_t_c)) begin
            load_a_q <= is_a_c;
            load_c_q <= is_t_c;
            ready_q  <= 1'b0;
            state_q  <= ST_LOAD;
          end else if (accept_c && is_c_c) begin
            key_time_q <= '0;
            show_q     <= 1'b0;
            timer_q    <= '0;
            state_q    <= ST_IDLE;
          end else begin
            // Idle cycle or illegal key: the inactivity timer keeps running.
            error_q <= accept_c;
            if (timeout_c) begin
              show_q  <= 1'b0;
              timer_q <= '0;
              state_q <= ST_IDLE;
            end else begin
              timer_q <= TIMER_W'(timer_q + 1'b1);
            end
          end
        end
        ST_LOAD: begin
          show_q  <= 1'b0;
          timer_q <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          show_q  <= 1'b0;
          timer_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign key_ready     = ready_q;
  assign key_time      = key_time_q;
  assign show_new_time = show_q;
  assign load_new_a    = load_a_q;
  assign load_new_c    = load_c_q;
  assign key_error     = error_q;

endmodule
